// File: rtl/rf_writeback_pkg.sv
// Shared core package for the register-file writeback path.
//   REG_ADDR_W  : architectural register address width (x0..x31)
//   WB_XLEN_MAX : widest data path a writeback queue may be built for
//   wb_entry_t  : one pending writeback {rd_addr, data}. The data field is
//                 sized for WB_XLEN_MAX so that a single typedef serves
//                 every XLEN. Users read only data[XLEN-1:0], and bits above
//                 XLEN are written as zero.
package rf_writeback_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int WB_XLEN_MAX = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]  rd_addr;
    logic [WB_XLEN_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Forwarding lookup over the pending writeback queue.
//   rs_addr : decode read address; x0 never hits
//   entries : queue storage, indexed by slot
//   valid   : per-slot occupancy
//   head    : oldest slot; age grows from head towards tail
//   hit/fwd : 1 and the youngest matching data, else 0 and 0
module wb_fwd_lookup
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic [REG_ADDR_W-1:0]    rs_addr,
  input  wb_entry_t                entries [DEPTH],
  input  logic [DEPTH-1:0]         valid,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     hit,
  output logic [XLEN-1:0]          fwd
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;

  // The walk goes from oldest to youngest, so the last match found is the
  // youngest one. The head slot is still valid while it is being written,
  // so a read in the same cycle still sees it.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((rs_addr != '0) && valid[idx] && (entries[idx].rd_addr == rs_addr)) begin
        hit = 1'b1;
        fwd = entries[idx].data[XLEN-1:0];
      end
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// In-order writeback queue between the ALU/LSU result buses and the
// register-file write port, with operand forwarding of pending results.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_alu_* / o_alu_rdy      : ALU result offer (has priority)
//   i_lsu_* / o_lsu_rdy      : load result offer
//   i_wb_stall               : write port unavailable this cycle
//   o_rd_wren/addr/data      : register-file write port (queue head)
//   i_rsN_addr/o_rsN_hit/fwd : forwarding lookups for decode
//   o_count/o_full/o_empty   : occupancy, from registered state only
//
// Handshake: an offer transfers on a rising edge where vld && rdy. Each
// rdy output is a function of the current state and the current inputs,
// and it never depends on the offered data. An accepted offer to x0 is
// consumed, and nothing is enqueued for it.
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_alu_vld,
  input  logic [4:0]               i_alu_rd_addr,
  input  logic [XLEN-1:0]          i_alu_data,
  output logic                     o_alu_rdy,
  input  logic                     i_lsu_vld,
  input  logic [4:0]               i_lsu_rd_addr,
  input  logic [XLEN-1:0]          i_lsu_data,
  output logic                     o_lsu_rdy,
  input  logic                     i_wb_stall,
  output logic                     o_rd_wren,
  output logic [4:0]               o_rd_addr,
  output logic [XLEN-1:0]          o_rd_data,
  input  logic [4:0]               i_rs1_addr,
  input  logic [4:0]               i_rs2_addr,
  output logic                     o_rs1_hit,
  output logic [XLEN-1:0]          o_rs1_fwd,
  output logic                     o_rs2_hit,
  output logic [XLEN-1:0]          o_rs2_fwd,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic      pop;
  logic      space;
  logic      accept;
  logic      push;
  wb_entry_t push_entry;

  assign o_count = count_q;
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);

  // Writes are suppressed in a reset cycle so that no pending data escapes.
  assign pop       = !o_empty && !i_wb_stall && !i_rst;
  assign o_rd_wren = pop;

  // A full queue can still take an entry in the cycle where its head retires.
  assign space     = !o_full || pop;
  assign o_alu_rdy = space;
  assign o_lsu_rdy = space && !i_alu_vld;

  always_comb begin
    push_entry = '0;
    if (i_alu_vld) begin
      push_entry.rd_addr          = i_alu_rd_addr;
      push_entry.data[XLEN-1:0]   = i_alu_data;
    end else begin
      push_entry.rd_addr          = i_lsu_rd_addr;
      push_entry.data[XLEN-1:0]   = i_lsu_data;
    end
  end

  assign accept = (i_alu_vld || i_lsu_vld) && space;
  assign push   = accept && (push_entry.rd_addr != '0) && !i_rst;

  assign o_rd_addr = o_empty ? '0 : mem[head_q].rd_addr;
  assign o_rd_data = o_empty ? '0 : mem[head_q].data[XLEN-1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // The clear comes first, so that when the queue is full and does a
      // push and a pop together (tail == head) the push's set takes effect.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset because occupancy is tracked by valid_q and count_q.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[tail_q] <= push_entry;
    end
  end

  // The lookups read registered state only, so the entry being pushed in
  // this cycle is not visible until the next cycle.
  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd_rs1 (
    .rs_addr (i_rs1_addr),
    .entries (mem),
    .valid   (valid_q),
    .head    (head_q),
    .hit     (o_rs1_hit),
    .fwd     (o_rs1_fwd)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd_rs2 (
    .rs_addr (i_rs2_addr),
    .entries (mem),
    .valid   (valid_q),
    .head    (head_q),
    .hit     (o_rs2_hit),
    .fwd     (o_rs2_fwd)
  );

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_alu_vld = 1'b0;
  logic [4:0]  i_alu_rd_addr = '0;
  logic [31:0] i_alu_data = '0;
  logic        o_alu_rdy;
  logic        i_lsu_vld = 1'b0;
  logic [4:0]  i_lsu_rd_addr = '0;
  logic [31:0] i_lsu_data = '0;
  logic        o_lsu_rdy;
  logic        i_wb_stall = 1'b0;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic        o_rs1_hit;
  logic [31:0] o_rs1_fwd;
  logic        o_rs2_hit;
  logic [31:0] o_rs2_fwd;
  logic [2:0]  o_count;
  logic        o_full;
  logic        o_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_writeback #(.DEPTH(4), .XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_alu_vld(i_alu_vld), .i_alu_rd_addr(i_alu_rd_addr), .i_alu_data(i_alu_data), .o_alu_rdy(o_alu_rdy),
    .i_lsu_vld(i_lsu_vld), .i_lsu_rd_addr(i_lsu_rd_addr), .i_lsu_data(i_lsu_data), .o_lsu_rdy(o_lsu_rdy),
    .i_wb_stall(i_wb_stall),
    .o_rd_wren(o_rd_wren), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_hit(o_rs1_hit), .o_rs1_fwd(o_rs1_fwd), .o_rs2_hit(o_rs2_hit), .o_rs2_fwd(o_rs2_fwd),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty)
  );

  // Clock and reset
  always #5 i_clk = ~i_clk;

  // Advance past the next rising edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic alu_offer(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_alu_vld = v; i_alu_rd_addr = a; i_alu_data = d;
  endtask

  task automatic lsu_offer(input logic v, input logic [4:0] a, input logic [31:0] d);
    i_lsu_vld = v; i_lsu_rd_addr = a; i_lsu_data = d;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    #1;
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %0b want 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %0b want 0", o_full); end
    n_cmp++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", o_count); end
    n_cmp++; if (o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %0b want 0", o_rd_wren); end
    n_cmp++; if (o_rd_addr !== 5'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", o_rd_addr); end
    n_cmp++; if (o_rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", o_rd_data); end
    n_cmp++; if ({o_rs1_hit, o_rs2_hit} !== 2'b00) begin n_fail++; $display("FAIL rst_hits got %b want 00", {o_rs1_hit, o_rs2_hit}); end
    n_cmp++; if ({o_rs1_fwd, o_rs2_fwd} !== 64'd0) begin n_fail++; $display("FAIL rst_fwd got %h want 0", {o_rs1_fwd, o_rs2_fwd}); end
    n_cmp++; if ({o_alu_rdy, o_lsu_rdy} !== 2'b11) begin n_fail++; $display("FAIL rst_rdy got %b want 11", {o_alu_rdy, o_lsu_rdy}); end
  endtask

  task automatic test_single();
    alu_offer(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (o_alu_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy got %0b want 1", o_alu_rdy); end
    n_cmp++; if (o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL single_nowr got %0b want 0", o_rd_wren); end
    tick();
    alu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_rd_wren !== 1'b1) begin n_fail++; $display("FAIL single_wren got %0b want 1", o_rd_wren); end
    n_cmp++; if (o_rd_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr got %0d want 5", o_rd_addr); end
    n_cmp++; if (o_rd_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got %h want deadbeef", o_rd_data); end
    tick();
    n_cmp++; if (o_empty !== 1'b1 || o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL single_after got empty=%0b wren=%0b want 1/0", o_empty, o_rd_wren); end
  endtask

  task automatic test_fill_drain();
    i_wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_offer(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
    end
    alu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", o_full); end
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", o_count); end
    n_cmp++; if (o_alu_rdy !== 1'b0) begin n_fail++; $display("FAIL fill_alu_rdy got %0b want 0", o_alu_rdy); end
    n_cmp++; if (o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL fill_stall_wren got %0b want 0", o_rd_wren); end
    i_wb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_cmp++;
      if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'(i) || o_rd_data !== 32'h100 + 32'(i)) begin
        n_fail++; $display("FAIL drain_%0d got wren=%0b addr=%0d data=%h want 1/%0d/%h", i, o_rd_wren, o_rd_addr, o_rd_data, i, 32'h100 + 32'(i));
      end
      tick();
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %0b want 1", o_empty); end
  endtask

  task automatic test_full_wrap();
    logic [4:0] exp_addr [5];
    exp_addr[0] = 5'd2; exp_addr[1] = 5'd3; exp_addr[2] = 5'd4; exp_addr[3] = 5'd7; exp_addr[4] = 5'd0;
    i_wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_offer(1'b1, 5'(i), 32'h200 + 32'(i));
      tick();
    end
    i_wb_stall = 1'b0;
    alu_offer(1'b1, 5'd7, 32'h77);
    #1;
    n_cmp++; if (o_alu_rdy !== 1'b1) begin n_fail++; $display("FAIL wrap_rdy got %0b want 1", o_alu_rdy); end
    n_cmp++; if (o_rd_addr !== 5'd1) begin n_fail++; $display("FAIL wrap_head got %0d want 1", o_rd_addr); end
    tick();
    alu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_count !== 3'd4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", o_count); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (o_rd_wren !== 1'b1 || o_rd_addr !== exp_addr[i]) begin
        n_fail++; $display("FAIL wrap_seq_%0d got wren=%0b addr=%0d want 1/%0d", i, o_rd_wren, o_rd_addr, exp_addr[i]);
      end
      if (i == 3) begin
        n_cmp++; if (o_rd_data !== 32'h77) begin n_fail++; $display("FAIL wrap_data got %h want 77", o_rd_data); end
      end
      tick();
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %0b want 1", o_empty); end
  endtask

  task automatic test_arbitration();
    alu_offer(1'b1, 5'd8, 32'hAAAA0008);
    lsu_offer(1'b1, 5'd9, 32'hBBBB0009);
    #1;
    n_cmp++; if ({o_alu_rdy, o_lsu_rdy} !== 2'b10) begin n_fail++; $display("FAIL arb_rdy got %b want 10", {o_alu_rdy, o_lsu_rdy}); end
    tick();
    alu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_lsu_rdy !== 1'b1) begin n_fail++; $display("FAIL arb_lsu_rdy got %0b want 1", o_lsu_rdy); end
    n_cmp++; if (o_rd_addr !== 5'd8 || o_rd_data !== 32'hAAAA0008) begin n_fail++; $display("FAIL arb_alu_wr got %0d/%h want 8/aaaa0008", o_rd_addr, o_rd_data); end
    tick();
    lsu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_rd_wren !== 1'b1 || o_rd_addr !== 5'd9 || o_rd_data !== 32'hBBBB0009) begin n_fail++; $display("FAIL arb_lsu_wr got %0b/%0d/%h want 1/9/bbbb0009", o_rd_wren, o_rd_addr, o_rd_data); end
    tick();
    n_cmp++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL arb_empty got %0b want 1", o_empty); end
  endtask

  task automatic test_forwarding();
    i_wb_stall = 1'b1;
    i_rs1_addr = 5'd3;
    i_rs2_addr = 5'd0;
    alu_offer(1'b1, 5'd3, 32'h11);
    #1;
    n_cmp++; if (o_rs1_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_push_excl got %0b want 0", o_rs1_hit); end
    tick();
    alu_offer(1'b1, 5'd3, 32'h22);
    #1;
    n_cmp++; if (o_rs1_hit !== 1'b1 || o_rs1_fwd !== 32'h11) begin n_fail++; $display("FAIL fwd_one got %0b/%h want 1/11", o_rs1_hit, o_rs1_fwd); end
    tick();
    alu_offer(1'b1, 5'd0, 32'h99);
    #1;
    n_cmp++; if (o_rs1_hit !== 1'b1 || o_rs1_fwd !== 32'h22) begin n_fail++; $display("FAIL fwd_young got %0b/%h want 1/22", o_rs1_hit, o_rs1_fwd); end
    n_cmp++; if (o_rs2_hit !== 1'b0 || o_rs2_fwd !== 32'd0) begin n_fail++; $display("FAIL fwd_x0 got %0b/%h want 0/0", o_rs2_hit, o_rs2_fwd); end
    n_cmp++; if (o_alu_rdy !== 1'b1) begin n_fail++; $display("FAIL fwd_x0_rdy got %0b want 1", o_alu_rdy); end
    tick();
    alu_offer(1'b0, 5'd0, 32'd0);
    i_rs2_addr = 5'd4;
    #1;
    n_cmp++; if (o_count !== 3'd2) begin n_fail++; $display("FAIL fwd_x0_count got %0d want 2", o_count); end
    n_cmp++; if (o_rs2_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_nomatch got %0b want 0", o_rs2_hit); end
    i_wb_stall = 1'b0;
    #1;
    n_cmp++; if (o_rd_data !== 32'h11 || o_rs1_fwd !== 32'h22) begin n_fail++; $display("FAIL fwd_pop1 got %h/%h want 11/22", o_rd_data, o_rs1_fwd); end
    tick();
    n_cmp++; if (o_rd_wren !== 1'b1 || o_rs1_hit !== 1'b1 || o_rs1_fwd !== 32'h22) begin n_fail++; $display("FAIL fwd_head_wr got %0b/%0b/%h want 1/1/22", o_rd_wren, o_rs1_hit, o_rs1_fwd); end
    tick();
    n_cmp++; if (o_rs1_hit !== 1'b0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drained got %0b/%0b want 0/1", o_rs1_hit, o_empty); end
    i_rs1_addr = 5'd0;
    i_rs2_addr = 5'd0;
  endtask

  task automatic test_reset_mid();
    i_wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_offer(1'b1, 5'(10 + i), 32'hC0 + 32'(i));
      tick();
    end
    i_wb_stall = 1'b0;
    i_rst = 1'b1;
    alu_offer(1'b1, 5'd20, 32'hEE);
    #1;
    n_cmp++; if (o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL rmid_rst_wren got %0b want 0", o_rd_wren); end
    tick();
    i_rst = 1'b0;
    alu_offer(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (o_empty !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL rmid_empty got %0b/%0d want 1/0", o_empty, o_count); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (o_rd_wren !== 1'b0) begin n_fail++; $display("FAIL rmid_nowr_%0d got %0b want 0", i, o_rd_wren); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_wrap();
    test_arbitration();
    test_forwarding();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
